// File: rtl/xbar_slv_aw_w_arbiter.sv
// rtl/xbar_slv_aw_w_arbiter.sv - per-slave-port AW round-robin arbiter with in-order W steering
module xbar_slv_aw_w_arbiter #(
  parameter int NUM_MST      = 4,
  parameter int ID_WIDTH     = 4,
  parameter int W_FIFO_DEPTH = 4,
  parameter int IDX_W        = $clog2(NUM_MST)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_MST-1:0]          mst_aw_valid_i,
  input  logic [NUM_MST*ID_WIDTH-1:0] mst_aw_id_i,
  output logic [NUM_MST-1:0]          mst_aw_ready_o,
  output logic                        slv_aw_valid_o,
  output logic [ID_WIDTH+IDX_W-1:0]   slv_aw_id_o,
  input  logic                        slv_aw_ready_i,
  output logic [IDX_W-1:0]            aw_sel_o,
  input  logic [NUM_MST-1:0]          mst_w_valid_i,
  input  logic [NUM_MST-1:0]          mst_w_last_i,
  output logic [NUM_MST-1:0]          mst_w_ready_o,
  output logic                        slv_w_valid_o,
  output logic                        slv_w_last_o,
  input  logic                        slv_w_ready_i,
  output logic [IDX_W-1:0]            w_sel_o,
  output logic                        w_sel_valid_o
);
  localparam int PTR_W = $clog2(W_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(W_FIFO_DEPTH);
  localparam logic [IDX_W:0]   NUM_MST_C = (IDX_W+1)'(NUM_MST);

  typedef enum logic {ARB, HOLD} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, lock_idx_q, cand, aw_sel, head;
  logic [IDX_W:0]    scan_idx, next_rr;
  logic              any_req, full, aw_valid, push, pop;
  logic [ID_WIDTH-1:0] sel_id;
  logic [IDX_W-1:0]  fifo_q [W_FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Scanning from the far end down means the last hit wins, i.e. the one closest to rr_ptr.
  always_comb begin
    cand     = rr_ptr_q;
    any_req  = 1'b0;
    scan_idx = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (scan_idx >= NUM_MST_C) scan_idx = scan_idx - NUM_MST_C;
      if (mst_aw_valid_i[scan_idx[IDX_W-1:0]]) begin
        any_req = 1'b1;
        cand    = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign full     = (count_q == DEPTH_C);
  assign aw_sel   = (state_q == HOLD) ? lock_idx_q : cand;
  assign aw_valid = rst_ni && ((state_q == HOLD) || (any_req && !full));
  assign push     = aw_valid && slv_aw_ready_i;
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (aw_valid && !slv_aw_ready_i) state_d = HOLD;
      HOLD:    if (slv_aw_ready_i) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    sel_id         = '0;
    mst_aw_ready_o = '0;
    mst_w_ready_o  = '0;
    for (int m = 0; m < NUM_MST; m++) begin
      if (aw_sel == IDX_W'(m)) begin
        sel_id            = mst_aw_id_i[m*ID_WIDTH +: ID_WIDTH];
        mst_aw_ready_o[m] = push;
      end
      if (head == IDX_W'(m)) mst_w_ready_o[m] = w_sel_valid_o && slv_w_ready_i;
    end
  end

  // Outputs are forced to zero while reset is asserted, independent of the clock.
  assign slv_aw_valid_o = aw_valid;
  assign aw_sel_o       = rst_ni ? aw_sel : '0;
  assign slv_aw_id_o    = rst_ni ? {aw_sel, sel_id} : '0;
  assign w_sel_o        = head;
  assign w_sel_valid_o  = (count_q != '0);
  assign slv_w_valid_o  = w_sel_valid_o && mst_w_valid_i[head];
  assign slv_w_last_o   = w_sel_valid_o && mst_w_last_i[head];
  assign pop            = slv_w_valid_o && slv_w_ready_i && slv_w_last_o;

  always_comb begin
    next_rr = {1'b0, aw_sel} + (IDX_W+1)'(1);
    if (next_rr >= NUM_MST_C) next_rr = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int d = 0; d < W_FIFO_DEPTH; d++) fifo_q[d] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && aw_valid && !slv_aw_ready_i) lock_idx_q <= cand;
      if (push) begin
        fifo_q[wr_ptr_q] <= aw_sel;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        rr_ptr_q         <= next_rr[IDX_W-1:0];
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  hold_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == HOLD) |-> mst_aw_valid_i[lock_idx_q]);
`endif

endmodule

// File: tb/tb_xbar_slv_aw_w_arbiter.sv
// tb/tb_xbar_slv_aw_w_arbiter.sv - directed vector bench for xbar_slv_aw_w_arbiter
module tb_xbar_slv_aw_w_arbiter;
  logic        clk, rst_n;
  logic [3:0]  mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_last, mst_w_ready;
  logic [15:0] mst_aw_id;
  logic        slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_last, slv_w_ready, w_sel_valid;
  logic [5:0]  slv_aw_id;
  logic [1:0]  aw_sel, w_sel;
  int checks, errors;

  xbar_slv_aw_w_arbiter #(.NUM_MST(4), .ID_WIDTH(4), .W_FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_aw_valid_i(mst_aw_valid), .mst_aw_id_i(mst_aw_id), .mst_aw_ready_o(mst_aw_ready),
    .slv_aw_valid_o(slv_aw_valid), .slv_aw_id_o(slv_aw_id), .slv_aw_ready_i(slv_aw_ready),
    .aw_sel_o(aw_sel),
    .mst_w_valid_i(mst_w_valid), .mst_w_last_i(mst_w_last), .mst_w_ready_o(mst_w_ready),
    .slv_w_valid_o(slv_w_valid), .slv_w_last_o(slv_w_last), .slv_w_ready_i(slv_w_ready),
    .w_sel_o(w_sel), .w_sel_valid_o(w_sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] awv; logic awr; logic [3:0] wv; logic [3:0] wl; logic wr;
    logic e_awv; logic [1:0] e_sel; logic [5:0] e_id; logic [3:0] e_awr;
    logic e_wv; logic e_wl; logic [1:0] e_wsel; logic e_wselv; logic [3:0] e_wr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] awv, input logic awr, input logic [3:0] wv,
                       input logic [3:0] wl, input logic wr);
    mst_aw_valid = awv; slv_aw_ready = awr;
    mst_w_valid = wv; mst_w_last = wl; slv_w_ready = wr;
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " aw_valid"}, 32'(slv_aw_valid), 0);
    chk({tag, " aw_sel"}, 32'(aw_sel), 0);
    chk({tag, " aw_id"}, 32'(slv_aw_id), 0);
    chk({tag, " aw_ready"}, 32'(mst_aw_ready), 0);
    chk({tag, " w_valid"}, 32'(slv_w_valid), 0);
    chk({tag, " w_last"}, 32'(slv_w_last), 0);
    chk({tag, " w_ready"}, 32'(mst_w_ready), 0);
    chk({tag, " w_sel"}, 32'(w_sel), 0);
    chk({tag, " w_sel_valid"}, 32'(w_sel_valid), 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    mst_aw_id = {4'hD, 4'hC, 4'hB, 4'hA};
    rst_n = 1'b0;
    drive(4'b0101, 1'b1, 4'b1111, 4'b1111, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");

    // Masters 0 and 2 alternate until the FIFO fills, then the head bursts drain under a full FIFO.
    vecs[0] = '{4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 6'h0A, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[1] = '{4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 6'h2C, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
    vecs[2] = '{4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 6'h0A, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
    vecs[3] = '{4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 6'h2C, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
    vecs[4] = '{4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 6'h0A, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
    vecs[5] = '{4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 6'h0A, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
    vecs[6] = '{4'b0101, 1'b1, 4'b1111, 4'b0101, 1'b1, 1'b0, 2'd0, 6'h0A, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
    vecs[7] = '{4'b0101, 1'b1, 4'b1111, 4'b0101, 1'b1, 1'b1, 2'd0, 6'h0A, 4'b0001, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].awv, vecs[i].awr, vecs[i].wv, vecs[i].wl, vecs[i].wr);
      chk($sformatf("v%0d aw_valid", i), 32'(slv_aw_valid), 32'(vecs[i].e_awv));
      chk($sformatf("v%0d aw_sel", i), 32'(aw_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d aw_id", i), 32'(slv_aw_id), 32'(vecs[i].e_id));
      chk($sformatf("v%0d aw_ready", i), 32'(mst_aw_ready), 32'(vecs[i].e_awr));
      chk($sformatf("v%0d w_valid", i), 32'(slv_w_valid), 32'(vecs[i].e_wv));
      chk($sformatf("v%0d w_last", i), 32'(slv_w_last), 32'(vecs[i].e_wl));
      chk($sformatf("v%0d w_sel", i), 32'(w_sel), 32'(vecs[i].e_wsel));
      chk($sformatf("v%0d w_sel_valid", i), 32'(w_sel_valid), 32'(vecs[i].e_wselv));
      chk($sformatf("v%0d w_ready", i), 32'(mst_w_ready), 32'(vecs[i].e_wr));
      next_cycle();
    end

    // Grant held stable while slave AWREADY is low; master 0 wins next via rr wrap.
    do_reset();
    drive(4'b0010, 1'b0, 4'b0, 4'b0, 1'b0);
    chk("hold c0 valid", 32'(slv_aw_valid), 1); chk("hold c0 sel", 32'(aw_sel), 1);
    chk("hold c0 ready", 32'(mst_aw_ready), 0);
    for (int c = 1; c < 3; c++) begin
      next_cycle();
      drive(4'b0011, 1'b0, 4'b0, 4'b0, 1'b0);
      chk($sformatf("hold c%0d valid", c), 32'(slv_aw_valid), 1);
      chk($sformatf("hold c%0d sel", c), 32'(aw_sel), 1);
    end
    next_cycle();
    drive(4'b0011, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("hold hs sel", 32'(aw_sel), 1); chk("hold hs ready", 32'(mst_aw_ready), 4'b0010);
    next_cycle();
    drive(4'b0001, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("wrap sel", 32'(aw_sel), 0); chk("wrap ready", 32'(mst_aw_ready), 4'b0001);
    next_cycle();

    // W order follows AW order: master 3 burst of 4, then master 1 burst of 2.
    do_reset();
    drive(4'b1000, 1'b1, 4'b0, 4'b0, 1'b1);
    chk("ord aw3 sel", 32'(aw_sel), 3); chk("ord aw3 ready", 32'(mst_aw_ready), 4'b1000);
    next_cycle();
    drive(4'b0010, 1'b1, 4'b0, 4'b0, 1'b1);
    chk("ord aw1 sel", 32'(aw_sel), 1); chk("ord aw1 wsel", 32'(w_sel), 3);
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      drive(4'b0, 1'b0, 4'b1010, (k == 4) ? 4'b1000 : 4'b0000, 1'b1);
      chk($sformatf("ord beat%0d wsel", k), 32'(w_sel), 3);
      chk($sformatf("ord beat%0d wready", k), 32'(mst_w_ready), 4'b1000);
      chk($sformatf("ord beat%0d wlast", k), 32'(slv_w_last), (k == 4) ? 1 : 0);
      next_cycle();
    end
    drive(4'b0, 1'b0, 4'b0010, 4'b0000, 1'b1);
    chk("ord m1 wsel", 32'(w_sel), 1); chk("ord m1 wready", 32'(mst_w_ready), 4'b0010);
    chk("ord m1 wvalid", 32'(slv_w_valid), 1);
    next_cycle();
    drive(4'b0, 1'b0, 4'b0010, 4'b0010, 1'b1);
    chk("ord m1 last", 32'(slv_w_last), 1);
    next_cycle();
    drive(4'b0, 1'b0, 4'b0, 4'b0, 1'b1);
    chk("ord empty", 32'(w_sel_valid), 0);
    next_cycle();

    // W arriving before its AW stalls at the master.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(4'b0, 1'b0, 4'b0100, 4'b0100, 1'b1);
      chk($sformatf("early c%0d wvalid", c), 32'(slv_w_valid), 0);
      chk($sformatf("early c%0d wready", c), 32'(mst_w_ready), 0);
      next_cycle();
    end
    drive(4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1);
    chk("early push ready", 32'(mst_aw_ready), 4'b0100);
    chk("early push wvalid", 32'(slv_w_valid), 0);
    next_cycle();
    drive(4'b0, 1'b0, 4'b0100, 4'b0100, 1'b1);
    chk("early fwd wvalid", 32'(slv_w_valid), 1); chk("early fwd wsel", 32'(w_sel), 2);
    chk("early fwd wready", 32'(mst_w_ready), 4'b0100);
    next_cycle();
    drive(4'b0, 1'b0, 4'b0, 4'b0, 1'b1);
    chk("early popped", 32'(w_sel_valid), 0);
    next_cycle();

    // Asynchronous reset mid-burst with two bursts queued.
    do_reset();
    drive(4'b1010, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("rst push1 sel", 32'(aw_sel), 1);
    next_cycle();
    drive(4'b1010, 1'b1, 4'b0, 4'b0, 1'b0);
    chk("rst push3 sel", 32'(aw_sel), 3);
    next_cycle();
    drive(4'b1010, 1'b0, 4'b0010, 4'b0000, 1'b1);
    chk("rst mid wvalid", 32'(slv_w_valid), 1);
    next_cycle();
    mst_w_valid = 4'b1010;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    next_cycle();
    rst_n = 1'b1;
    drive(4'b1010, 1'b1, 4'b1010, 4'b0000, 1'b1);
    chk("post rst sel", 32'(aw_sel), 1); chk("post rst ready", 32'(mst_aw_ready), 4'b0010);
    chk("post rst wsel_valid", 32'(w_sel_valid), 0); chk("post rst wvalid", 32'(slv_w_valid), 0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xbar_slv_aw_w_arbiter.md
Name: xbar_slv_aw_w_arbiter

Overview:
- Per-slave-port write-path scheduler inside the AXI crossbar.
- Shares one slave AW channel among NUM_MST masters using a round-robin arbiter.
- Records each granted master index in an in-order FIFO, so W beats are steered to the slave in AW acceptance order, one burst at a time until WLAST.
- Extends the AW ID with the master index so that B responses can be routed back to the issuing master.

Parameters:
- NUM_MST, 4: number of requesting master ports (≥2).
- ID_WIDTH, 4: master-side AXI ID width.
- W_FIFO_DEPTH, 4: maximum AW-accepted bursts whose W data is still outstanding (power of 2, ≥2).
- IDX_W, $clog2(NUM_MST): derived; master index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mst_aw_valid_i  in  NUM_MST  per-master AWVALID.
- mst_aw_id_i  in  NUM_MST*ID_WIDTH  per-master AWID, master m in bits [m*ID_WIDTH +: ID_WIDTH].
- mst_aw_ready_o  out  NUM_MST  per-master AWREADY.
- slv_aw_valid_o  out  1  slave AWVALID.
- slv_aw_id_o  out  ID_WIDTH+IDX_W  {granted index, granted AWID}.
- slv_aw_ready_i  in  1  slave AWREADY.
- aw_sel_o  out  IDX_W  AW payload mux select for the external datapath.
- mst_w_valid_i  in  NUM_MST  per-master WVALID.
- mst_w_last_i  in  NUM_MST  per-master WLAST.
- mst_w_ready_o  out  NUM_MST  per-master WREADY.
- slv_w_valid_o  out  1  slave WVALID.
- slv_w_last_o  out  1  slave WLAST.
- slv_w_ready_i  in  1  slave WREADY.
- w_sel_o  out  IDX_W  W payload mux select, equal to the FIFO head.
- w_sel_valid_o  out  1  FIFO non-empty.

Behaviour:
- Reset (async assert, sync deassert):
  - FSM returns to ARB; rr_ptr=0; FIFO empty (count=0, rd/wr pointers=0); lock index=0.
  - All *_valid_o, *_ready_o, w_sel_valid_o are 0.
  - aw_sel_o, w_sel_o, slv_aw_id_o are 0.
  - Reset mid-burst discards all pending grants and partial bursts.
- AW FSM, states ARB and HOLD:
  - ARB: candidate = the first m with mst_aw_valid_i[m]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_MST.
    - slv_aw_valid_o = (any request) && (count < W_FIFO_DEPTH).
    - aw_sel_o = candidate.
    - Slave valid high and slv_aw_ready_i=1: handshake in the same cycle (zero latency). Stay in ARB.
    - Slave valid high and slv_aw_ready_i=0: register candidate as lock index and go to HOLD.
  - HOLD: aw_sel_o = lock index; slv_aw_valid_o=1 unconditionally. The grant must not change until the handshake (AXI stability).
    - Return to ARB on slv_aw_ready_i=1.
    - A locked master dropping AWVALID in HOLD is a protocol violation. It is flagged by a simulation assertion; the design stays in HOLD.
- mst_aw_ready_o[m] = slv_aw_ready_i && slv_aw_valid_o && (m == aw_sel_o). All other bits are 0.
- slv_aw_id_o = {aw_sel_o, mst_aw_id_i[aw_sel_o]}.
- On every AW handshake:
  - push aw_sel_o into the FIFO;
  - rr_ptr ← (aw_sel_o+1) mod NUM_MST, with explicit wrap for non-power-of-2 NUM_MST.
- FIFO full (count == W_FIFO_DEPTH):
  - In ARB, slv_aw_valid_o=0 and no new grant is offered, even if a pop happens in the same cycle (no bypass).
  - HOLD is never entered while full, because it is entered only with valid asserted.
- W steering, FIFO non-empty:
  - w_sel_o = head; w_sel_valid_o=1.
  - slv_w_valid_o = mst_w_valid_i[head]; slv_w_last_o = mst_w_last_i[head].
  - mst_w_ready_o[head] = slv_w_ready_i; all other bits are 0.
- W steering, FIFO empty:
  - slv_w_valid_o=0, slv_w_last_o=0, all mst_w_ready_o=0.
  - W data issued before its AW stalls at the master.
- Pop on slv_w_valid_o && slv_w_ready_i && slv_w_last_o. The next head takes effect the following cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop with count=0 cannot occur.
- count width is $clog2(W_FIFO_DEPTH)+1.

Test Plan:
- Reset, then masters 0 and 2 assert AW continuously with slv_aw_ready_i=1:
  - grant order 0,2,0,2;
  - slv_aw_id_o[top IDX_W bits] matches each grant;
  - FIFO holds 0,2,0,2 and then blocks (count=4, slv_aw_valid_o=0).
- Slave AWREADY low for 3 cycles while master 1 is granted and master 0 raises AWVALID:
  - aw_sel_o stays 1 and slv_aw_valid_o stays high for all 3 cycles;
  - after the handshake, the next grant is master 0 (rr_ptr=2 wraps to 0 when 2 and 3 are idle).
- AW accepted from master 3 (burst of 4 beats), then master 1 (burst of 2 beats):
  - W from master 1 is stalled (mst_w_ready_o[1]=0) until master 3's beat 4 with WLAST is handshaken;
  - then w_sel_o=1 on the next cycle.
- W valid from master 2 with an empty FIFO: slv_w_valid_o=0 and mst_w_ready_o=0 until master 2's AW handshake; first beat forwarded the cycle after the push.
- FIFO full and, in the same cycle, the last beat of the head burst is accepted:
  - slv_aw_valid_o=0 that cycle;
  - a grant is offered the next cycle with count=3.
- rst_ni pulsed low mid-burst with count=2: all outputs 0 immediately (asynchronously); after release, rr_ptr=0, FIFO empty, and first grant goes to the lowest active master.
